// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux channel-scan sequencer.
// States, select width, channel count and the all-channels mask.
package mux_scan_pkg;

    localparam int SEL_W  = 2;
    localparam int NUM_CH = 4;

    localparam logic [NUM_CH-1:0] ALL_CH = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_e;

endpackage

// File: rtl/mux_scan_next.sv
// Priority finder: next higher enabled channel above sel,
// lowest enabled channel, and whether a higher one exists.
import mux_scan_pkg::*;

module mux_scan_next (
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [SEL_W-1:0]  sel_i,
    output logic [SEL_W-1:0]  next_o,
    output logic [SEL_W-1:0]  lowest_o,
    output logic              has_next_o
);

    // Descending scans so the lowest qualifying channel is written last.
    always_comb begin
        next_o     = sel_i;
        lowest_o   = '0;
        has_next_o = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                lowest_o = SEL_W'(i);
                if (i > int'(sel_i)) begin
                    next_o     = SEL_W'(i);
                    has_next_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Channel-scan sequencer driving the 4:1 mux select with settle/sample.
// Optional MUX_SCAN_MASK_EN: honour ch_mask; otherwise scan all channels.
import mux_scan_pkg::*;

module mux_scan_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [NUM_CH-1:0]  ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               smp_ready,
    output logic [SEL_W-1:0]   sel,
    output logic               smp_valid,
    output logic               busy,
    output logic               done
);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DWELL_W-1:0]  cnt_q, cnt_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic                cont_q, cont_d;
    logic                done_q, done_d;
    logic                valid_q, busy_q;

    logic [NUM_CH-1:0]   start_mask;
    logic [NUM_CH-1:0]   find_mask;
    logic [SEL_W-1:0]    next_ch, low_ch;
    logic                has_next;

`ifdef MUX_SCAN_MASK_EN
    assign start_mask = ch_mask;
`else
    // Forcing all bits set makes the mask irrelevant and start always valid.
    assign start_mask = ch_mask | ALL_CH;
`endif

    assign find_mask = (state_q == IDLE) ? start_mask : mask_q;

    mux_scan_next u_next (
        .mask_i     (find_mask),
        .sel_i      (sel_q),
        .next_o     (next_ch),
        .lowest_o   (low_ch),
        .has_next_o (has_next)
    );

    // Next-state logic: scan sequencing, dwell countdown, handshake.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        mask_d  = mask_q;
        cont_d  = cont_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !stop && (start_mask != '0)) begin
                    cont_d  = cont;
                    mask_d  = start_mask;
                    dwell_d = dwell;
                    sel_d   = low_ch;
                    cnt_d   = dwell;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SAMPLE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (smp_ready) begin
                    if (has_next) begin
                        sel_d   = next_ch;
                        cnt_d   = dwell_q;
                        state_d = SETTLE;
                    end else if (cont_q) begin
                        sel_d   = low_ch;
                        cnt_d   = dwell_q;
                        state_d = SETTLE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched config and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            mask_q  <= '0;
            cont_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            mask_q  <= mask_d;
            cont_q  <= cont_d;
            done_q  <= done_d;
            valid_q <= (state_d == SAMPLE);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign sel       = sel_q;
    assign smp_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
